// File: rtl/rc4_stream_cipher.sv
// RC4 stream cipher: byte-serial key load, KSA, optional drop-N, then dout = din ^ keystream
// with valid/ready on key, input and output. rekey returns to key load without reset.
module rc4_stream_cipher #(
    parameter int KEY_BYTES_MAX = 16,
    parameter int DISCARD       = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_valid,
    input  logic [7:0] i_key_byte,
    input  logic       i_key_last,
    output logic       o_key_ready,
    output logic       o_key_trunc,
    input  logic       i_rekey,
    output logic       o_init_done,
    input  logic       i_din_valid,
    input  logic [7:0] i_din,
    output logic       o_din_ready,
    output logic       o_dout_valid,
    output logic [7:0] o_dout,
    input  logic       i_dout_ready
);

    localparam int KLW = $clog2(KEY_BYTES_MAX + 1);
    localparam int KIW = (KEY_BYTES_MAX > 1) ? $clog2(KEY_BYTES_MAX) : 1;
    localparam int DW  = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
    localparam logic [KLW-1:0] KEY_MAX_L = KLW'(KEY_BYTES_MAX);

    // States: KEY load | FILL S=identity | KSA_RD/KSA_SW | DISC drop byte | PRGA_A/B/C generate, C holds ks
    typedef enum logic [2:0] {
        ST_KEY, ST_FILL, ST_KSA_RD, ST_KSA_SW, ST_DISC, ST_PRGA_A, ST_PRGA_B, ST_PRGA_C
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_s [256];
    logic [7:0]     r_key [KEY_BYTES_MAX];
    logic [7:0]     r_i;
    logic [7:0]     r_j;
    logic [7:0]     r_t;
    logic [7:0]     r_ks;
    logic [7:0]     r_dout;
    logic [KLW-1:0] r_key_len;
    logic [KLW-1:0] r_kidx;
    logic [DW-1:0]  r_disc_cnt;
    logic           r_key_trunc;
    logic           r_init_done;
    logic           r_ks_held;
    logic           r_dout_valid;
    logic [7:0]     w_i_inc;
    logic           w_din_acc;
    logic           w_kidx_wrap;
    logic           w_key_room;

    assign w_i_inc     = r_i + 8'd1;
    assign w_kidx_wrap = ((r_kidx + KLW'(1)) == r_key_len);
    assign w_key_room  = (r_key_len < KEY_MAX_L);

    assign o_key_ready  = (r_state == ST_KEY);
    assign o_din_ready  = r_init_done && r_ks_held && (!r_dout_valid || i_dout_ready);
    assign w_din_acc    = i_din_valid && o_din_ready;
    assign o_key_trunc  = r_key_trunc;
    assign o_init_done  = r_init_done;
    assign o_dout_valid = r_dout_valid;
    assign o_dout       = r_dout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_KEY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_KEY:    if (i_key_valid && i_key_last) w_state_nxt = ST_FILL;
            ST_FILL:   if (r_i == 8'hFF) w_state_nxt = ST_KSA_RD;
            ST_KSA_RD: w_state_nxt = ST_KSA_SW;
            ST_KSA_SW: w_state_nxt = (r_i == 8'hFF) ? ST_PRGA_A : ST_KSA_RD;
            ST_DISC:   w_state_nxt = ST_PRGA_A;
            ST_PRGA_A: w_state_nxt = ST_PRGA_B;
            ST_PRGA_B: w_state_nxt = r_init_done ? ST_PRGA_C : ST_DISC;
            ST_PRGA_C: if (r_ks_held && w_din_acc) w_state_nxt = ST_PRGA_A;
            default:   w_state_nxt = ST_KEY;
        endcase
        if (i_rekey) begin
            w_state_nxt = ST_KEY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_rekey) begin
            r_i          <= 8'd0;
            r_j          <= 8'd0;
            r_t          <= 8'd0;
            r_ks         <= 8'd0;
            r_dout       <= 8'd0;
            r_key_len    <= '0;
            r_kidx       <= '0;
            r_disc_cnt   <= '0;
            r_key_trunc  <= 1'b0;
            r_init_done  <= 1'b0;
            r_ks_held    <= 1'b0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_din_acc) begin
                r_dout       <= i_din ^ r_ks;
                r_dout_valid <= 1'b1;
            end else if (i_dout_ready) begin
                r_dout_valid <= 1'b0;
            end
            case (r_state)
                ST_KEY: begin
                    if (i_key_valid) begin
                        if (w_key_room) begin
                            r_key_len <= r_key_len + KLW'(1);
                        end else begin
                            r_key_trunc <= 1'b1;
                        end
                        if (i_key_last) begin
                            r_i <= 8'd0;
                        end
                    end
                end
                ST_FILL: begin
                    r_i <= w_i_inc;
                    if (r_i == 8'hFF) begin
                        r_j    <= 8'd0;
                        r_kidx <= '0;
                    end
                end
                ST_KSA_RD: begin
                    r_j <= r_j + r_s[r_i] + r_key[r_kidx[KIW-1:0]];
                end
                ST_KSA_SW: begin
                    r_i    <= w_i_inc;
                    r_kidx <= w_kidx_wrap ? '0 : r_kidx + KLW'(1);
                    if (r_i == 8'hFF) begin
                        r_j         <= 8'd0;
                        r_disc_cnt  <= DW'(DISCARD);
                        r_init_done <= (DISCARD == 0);
                    end
                end
                ST_DISC: begin
                    r_disc_cnt <= r_disc_cnt - DW'(1);
                    if (r_disc_cnt == DW'(1)) begin
                        r_init_done <= 1'b1;
                    end
                end
                ST_PRGA_A: begin
                    r_i <= w_i_inc;
                    r_j <= r_j + r_s[w_i_inc];
                end
                ST_PRGA_B: begin
                    r_t <= r_s[r_i] + r_s[r_j];
                end
                ST_PRGA_C: begin
                    if (!r_ks_held) begin
                        r_ks      <= r_s[r_t];
                        r_ks_held <= 1'b1;
                    end else if (w_din_acc) begin
                        r_ks_held <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bytes beyond KEY_BYTES_MAX are counted as truncation only, never stored.
    always_ff @(posedge i_clk) begin
        if ((r_state == ST_KEY) && i_key_valid && w_key_room) begin
            r_key[r_key_len[KIW-1:0]] <= i_key_byte;
        end
    end

    always_ff @(posedge i_clk) begin
        case (r_state)
            ST_FILL: r_s[r_i] <= r_i;
            ST_KSA_SW, ST_PRGA_B: begin
                r_s[r_i] <= r_s[r_j];
                r_s[r_j] <= r_s[r_i];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_stream_cipher.sv
// Directed bench for rc4_stream_cipher: default, drop-2 and 4-byte-key instances
// driven on negedge, sampled #1 later; hand vectors plus a reference RC4 for the truncated key.
module tb_rc4_stream_cipher;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid [3];
    logic [7:0] key_byte [3];
    logic       key_last [3];
    logic       rekey [3];
    logic       din_valid [3];
    logic [7:0] din [3];
    logic       dout_ready [3];
    logic       key_ready [3];
    logic       key_trunc [3];
    logic       init_done [3];
    logic       din_ready [3];
    logic       dout_valid [3];
    logic [7:0] dout [3];

    int checks = 0;
    int errors = 0;
    logic [7:0] din_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] model_q [$];

    always #5 clk = ~clk;

    rc4_stream_cipher u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_key_valid(key_valid[0]), .i_key_byte(key_byte[0]), .i_key_last(key_last[0]),
        .o_key_ready(key_ready[0]), .o_key_trunc(key_trunc[0]), .i_rekey(rekey[0]),
        .o_init_done(init_done[0]), .i_din_valid(din_valid[0]), .i_din(din[0]),
        .o_din_ready(din_ready[0]), .o_dout_valid(dout_valid[0]), .o_dout(dout[0]),
        .i_dout_ready(dout_ready[0])
    );

    rc4_stream_cipher #(.DISCARD(2)) u_dut_d2 (
        .i_clk(clk), .i_rst(rst),
        .i_key_valid(key_valid[1]), .i_key_byte(key_byte[1]), .i_key_last(key_last[1]),
        .o_key_ready(key_ready[1]), .o_key_trunc(key_trunc[1]), .i_rekey(rekey[1]),
        .o_init_done(init_done[1]), .i_din_valid(din_valid[1]), .i_din(din[1]),
        .o_din_ready(din_ready[1]), .o_dout_valid(dout_valid[1]), .o_dout(dout[1]),
        .i_dout_ready(dout_ready[1])
    );

    rc4_stream_cipher #(.KEY_BYTES_MAX(4)) u_dut_k4 (
        .i_clk(clk), .i_rst(rst),
        .i_key_valid(key_valid[2]), .i_key_byte(key_byte[2]), .i_key_last(key_last[2]),
        .o_key_ready(key_ready[2]), .o_key_trunc(key_trunc[2]), .i_rekey(rekey[2]),
        .o_init_done(init_done[2]), .i_din_valid(din_valid[2]), .i_din(din[2]),
        .o_din_ready(din_ready[2]), .o_dout_valid(dout_valid[2]), .o_dout(dout[2]),
        .i_dout_ready(dout_ready[2])
    );

    function automatic void rc4_model(input string key, input int kmax, input int n);
        int s [256];
        int i;
        int j;
        int t;
        int kl;
        kl = (key.len() < kmax) ? key.len() : kmax;
        for (int a = 0; a < 256; a++) s[a] = a;
        j = 0;
        for (int a = 0; a < 256; a++) begin
            j = (j + s[a] + int'(key[a % kl])) % 256;
            t = s[a]; s[a] = s[j]; s[j] = t;
        end
        i = 0;
        j = 0;
        model_q.delete();
        for (int a = 0; a < n; a++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            model_q.push_back(8'(s[(s[i] + s[j]) % 256]));
        end
    endfunction

    function automatic void set_din_str(input string s);
        din_q.delete();
        for (int n = 0; n < s.len(); n++) din_q.push_back(s[n]);
    endfunction

    function automatic void set_din_zero(input int n);
        din_q.delete();
        for (int k = 0; k < n; k++) din_q.push_back(8'h00);
    endfunction

    function automatic void set_exp(input logic [127:0] v, input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(v[8*(n-1-k) +: 8]);
    endfunction

    task automatic load_key(input int d, input string k, input bit wait_done, output int lat);
        int cyc;
        lat = -1;
        for (int n = 0; n < k.len(); n++) begin
            @(negedge clk);
            key_valid[d] = 1'b1;
            key_byte[d]  = k[n];
            key_last[d]  = (n == k.len() - 1);
            #1;
            if (n == 0) begin
                checks++;
                if (key_ready[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL key_ready_%0d: got %b required 1", d, key_ready[d]);
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        key_valid[d] = 1'b0;
        key_last[d]  = 1'b0;
        if (wait_done) begin
            cyc = 1;
            while (init_done[d] !== 1'b1 && cyc < 3000) begin
                @(negedge clk);
                cyc++;
            end
            lat = cyc;
        end
    endtask

    task automatic run_stream(input int d, input bit stall, input string name);
        int tx;
        int rx;
        int cyc;
        bit was_stalled;
        logic [7:0] held;
        tx = 0; rx = 0; cyc = 0; was_stalled = 1'b0; held = 8'h00;
        while (rx < exp_q.size() && cyc < 2000) begin
            @(negedge clk);
            dout_ready[d] = stall ? ($urandom_range(2, 0) != 0) : 1'b1;
            if (tx < din_q.size()) begin
                din_valid[d] = 1'b1;
                din[d] = din_q[tx];
            end else begin
                din_valid[d] = 1'b0;
            end
            #1;
            if (was_stalled) begin
                checks++;
                if (dout_valid[d] !== 1'b1 || dout[d] !== held) begin
                    errors++;
                    $display("FAIL %s_hold: valid=%b dout=%h required 1 %h", name, dout_valid[d], dout[d], held);
                end
            end
            was_stalled = dout_valid[d] && !dout_ready[d];
            held = dout[d];
            if (dout_valid[d] && dout_ready[d]) begin
                checks++;
                if (dout[d] !== exp_q[rx]) begin
                    errors++;
                    $display("FAIL %s_byte%0d: got %h required %h", name, rx, dout[d], exp_q[rx]);
                end
                rx++;
            end
            if (din_valid[d] && din_ready[d]) tx++;
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        din_valid[d]  = 1'b0;
        dout_ready[d] = 1'b0;
        #1;
        checks++;
        if (rx != exp_q.size() || dout_valid[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s_count: got %0d bytes valid=%b required %0d bytes valid=0", name, rx, dout_valid[d], exp_q.size());
        end
    endtask

    task automatic check_idle(input int d, input string name);
        checks++;
        if ({key_ready[d], init_done[d], dout_valid[d], din_ready[d], key_trunc[d]} !== 5'b10000
            || dout[d] !== 8'h00) begin
            errors++;
            $display("FAIL %s: got rdy/done/dv/dinrdy/trunc=%b dout=%h required 10000 00", name,
                     {key_ready[d], init_done[d], dout_valid[d], din_ready[d], key_trunc[d]}, dout[d]);
        end
    endtask

    task automatic do_rekey(input int d, input string name);
        @(negedge clk);
        rekey[d] = 1'b1;
        @(negedge clk);
        rekey[d] = 1'b0;
        #1;
        check_idle(d, name);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_idle(0, name);
        rst = 1'b0;
    endtask

    task automatic check_lat(input int lat, input int req, input string name);
        checks++;
        if (lat != req) begin
            errors++;
            $display("FAIL %s: init_done at N+%0d required N+%0d", name, lat, req);
        end
    endtask

    task automatic hold_one_byte(input int d);
        int g;
        g = 0;
        while (g < 20) begin
            @(negedge clk);
            din_valid[d] = 1'b1; din[d] = 8'h55; dout_ready[d] = 1'b0;
            #1;
            if (din_ready[d]) begin
                @(posedge clk);
                break;
            end
            g++;
        end
        @(negedge clk);
        din_valid[d] = 1'b0;
        #1;
        checks++;
        if (dout_valid[d] !== 1'b1) begin
            errors++;
            $display("FAIL buffered_byte_%0d: dout_valid=%b required 1", d, dout_valid[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_idle(0, "reset_dut0");
        check_idle(1, "reset_dut1");
        check_idle(2, "reset_dut2");
        rst = 1'b0;
    endtask

    task automatic test_key_vector();
        int lat;
        load_key(0, "Key", 1'b1, lat);
        check_lat(lat, 769, "init_lat_key");
        set_din_str("Plaintext");
        set_exp(128'hBBF316E8D940AF0AD3, 9);
        run_stream(0, 1'b0, "key_plain");
    endtask

    task automatic test_stall();
        int lat;
        do_rekey(0, "rekey_before_secret");
        load_key(0, "Secret", 1'b1, lat);
        checks++;
        if (key_trunc[0] !== 1'b0) begin
            errors++;
            $display("FAIL trunc_secret16: got %b required 0", key_trunc[0]);
        end
        set_din_str("Attack at dawn");
        set_exp(128'h45A01F645FC35B383552544B9BF5, 14);
        run_stream(0, 1'b1, "secret_stall");
    endtask

    task automatic test_wiki_rekey();
        int lat;
        do_rekey(0, "rekey_before_wiki");
        load_key(0, "Wiki", 1'b1, lat);
        set_din_zero(5);
        set_exp(128'h6044DB6D41, 5);
        run_stream(0, 1'b0, "wiki_ks");
        hold_one_byte(0);
        do_rekey(0, "rekey_mid_stream");
        load_key(0, "Key", 1'b1, lat);
        set_din_zero(3);
        set_exp(128'hEB9F77, 3);
        run_stream(0, 1'b0, "key_after_rekey");
    endtask

    task automatic test_discard();
        int lat;
        load_key(1, "Key", 1'b1, lat);
        check_lat(lat, 775, "init_lat_drop2");
        set_din_zero(3);
        set_exp(128'h7781B7, 3);
        run_stream(1, 1'b0, "drop2");
    endtask

    task automatic test_trunc();
        int lat;
        load_key(2, "Secret", 1'b1, lat);
        checks++;
        if (key_trunc[2] !== 1'b1) begin
            errors++;
            $display("FAIL trunc_set: got %b required 1", key_trunc[2]);
        end
        set_din_str("Attack at dawn");
        rc4_model("Secr", 256, 14);
        exp_q.delete();
        for (int k = 0; k < 14; k++) exp_q.push_back(din_q[k] ^ model_q[k]);
        run_stream(2, 1'b0, "trunc_secr");
        do_rekey(2, "trunc_cleared_on_rekey");
    endtask

    task automatic test_rst_mid();
        int lat;
        do_rekey(0, "rekey_before_rst_ksa");
        load_key(0, "Key", 1'b0, lat);
        repeat (300) begin
            @(negedge clk);
            din_valid[0] = 1'b1; din[0] = 8'hA5; dout_ready[0] = 1'b1;
        end
        #1;
        checks++;
        if (din_ready[0] !== 1'b0 || dout_valid[0] !== 1'b0 || init_done[0] !== 1'b0) begin
            errors++;
            $display("FAIL din_before_init: dinrdy=%b dv=%b done=%b required 0 0 0", din_ready[0], dout_valid[0], init_done[0]);
        end
        @(negedge clk);
        din_valid[0] = 1'b0; dout_ready[0] = 1'b0;
        do_reset("rst_mid_ksa");
        load_key(0, "Key", 1'b1, lat);
        set_din_str("Pla");
        set_exp(128'hBBF316, 3);
        run_stream(0, 1'b0, "pre_rst_stream");
        hold_one_byte(0);
        do_reset("rst_mid_stream");
        load_key(0, "Key", 1'b1, lat);
        check_lat(lat, 769, "init_lat_after_rst");
        set_din_str("Plaintext");
        set_exp(128'hBBF316E8D940AF0AD3, 9);
        run_stream(0, 1'b0, "key_plain_again");
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            key_valid[d] = 1'b0; key_byte[d] = 8'h00; key_last[d] = 1'b0; rekey[d] = 1'b0;
            din_valid[d] = 1'b0; din[d] = 8'h00; dout_ready[d] = 1'b0;
        end
        test_reset();
        test_key_vector();
        test_stall();
        test_wiki_rekey();
        test_discard();
        test_trunc();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
